spi_burst_ram: RTL
==================

# spi_burst_ram

Command-decoded synchronous single-port RAM sitting behind the SPI slave's parallel side, successor to the fixed 8-bit/256-word command RAM. Generalised in data width, address width and burst length; adds post-incrementing writes, multi-word burst reads with `tx_ready` back-pressure, an `rx_ready` accept flag and a dropped-command error pulse.

## Interface
- `DATA_W`, default 8: RAM word width and command payload width.
- `ADDR_W`, default 8: address width. Depth is 2**ADDR_W words. Must satisfy ADDR_W <= DATA_W.
- `LEN_W`, default 4: burst-length field width. Must satisfy LEN_W <= DATA_W.
- `AUTO_INC`, default 1: 1 post-increments the write address after each data write; 0 holds it.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `din` in DATA_W+2: command; [DATA_W+1:DATA_W] is the opcode, [DATA_W-1:0] is the payload.
- `rx_valid` in 1: `din` valid this cycle.
- `rx_ready` out 1: block accepts a command this cycle.
- `dout` out DATA_W: read data.
- `tx_valid` out 1: `dout` valid; held until taken.
- `tx_ready` in 1: consumer takes `dout` when high together with `tx_valid`.
- `cmd_err` out 1: one-cycle pulse when a command was dropped.

## Operation
- Reset values: `dout`=0, `tx_valid`=0, `cmd_err`=0, wr_addr=0, rd_addr=0, remaining count=0, state=IDLE. `rx_ready`=1 (combinational from IDLE). RAM contents are not reset.
- A command is accepted when `rx_valid && rx_ready`. If `rx_valid && !rx_ready`, the command is dropped and `cmd_err` pulses on the next cycle. The block has no other effect.
- Opcodes:
  - 00: wr_addr <= payload[ADDR_W-1:0].
  - 01: RAM[wr_addr] <= payload. If AUTO_INC=1, wr_addr <= wr_addr+1.
  - 10: rd_addr <= payload[ADDR_W-1:0].
  - 11: burst read of payload[LEN_W-1:0]+1 words starting at rd_addr. remaining <= payload[LEN_W-1:0]. State goes to FETCH.
- FSM:
  - IDLE: `rx_ready`=1. Opcode 11 -> FETCH. All other opcodes stay in IDLE.
  - FETCH: `rx_ready`=0. dout <= RAM[rd_addr], tx_valid <= 1, rd_addr <= rd_addr+1. Next state is HOLD.
  - HOLD: `rx_ready`=0. `dout` and `tx_valid` are held stable until `tx_ready`. On the handshake:
    - if remaining==0: tx_valid <= 0 and go to IDLE.
    - otherwise: remaining <= remaining-1, tx_valid <= 0, and go to FETCH.
- Address arithmetic is modulo 2**ADDR_W. Both wr_addr and rd_addr wrap from all-ones to 0 without error.
- Payload bits above ADDR_W in opcodes 00 and 10 are ignored. Payload bits above LEN_W in opcode 11 are ignored.
- After a burst, rd_addr = start + N (mod depth). Back-to-back opcode 11 commands therefore stream sequential memory.

## Timing
- Write: the RAM is updated at the accepting edge. A read of the same address that is accepted on the following edge returns the new data.
- Read latency: opcode 11 is accepted at edge k. `tx_valid` rises after edge k+1 with the word.
  - With `tx_ready` tied high, a burst delivers one word every 2 cycles.
  - `tx_valid` is low for one cycle between words.
- `tx_ready` asserted while `tx_valid`=0 is ignored.
- `rx_ready` falls in the cycle after the accepting edge of opcode 11. It returns high in the cycle after the final handshake.
- `cmd_err` is a registered single-cycle pulse per dropped command. A dropped command on consecutive cycles gives consecutive pulses.
- Asserting reset mid-burst clears `tx_valid` immediately (asynchronously) and aborts the burst. The partially read data is lost, and RAM is unaffected.

## Structure
- Shared package `spi_ram_pkg` holds:
  - opcode localparams OP_SET_WADDR=2'b00, OP_WRITE=2'b01, OP_SET_RADDR=2'b10, OP_READ=2'b11;
  - the state encoding (IDLE, FETCH, HOLD).
- One sub-module, `sp_ram`: a parametrised (DATA_W, ADDR_W) synchronous single-port array with `we`, `addr`, `wdata` and a registered `rdata`. Only one access occurs per cycle; the FSM guarantees that writes never coincide with FETCH.
- The top module holds the command decoder, the address and count registers, the FSM and the output handshake.

## Test plan
- Reset then idle: after `rst`, `dout`=0, `tx_valid`=0, `rx_ready`=1, `cmd_err`=0.
- Write 0x00 at addr, then data 0xA1, 0xA2, 0xA3 (AUTO_INC=1); set raddr 0x00; read len=2.
  - Required: three words 0xA1, 0xA2, 0xA3, each with `tx_valid` one cycle after FETCH; `rx_ready` then returns to 1.
- Wrap-around: waddr 0xFF; write 0x11, 0x22; raddr 0xFF; read len=1 -> 0x11, then 0x22 (the second word read from address 0x00).
- Back-pressure: burst len=1 with `tx_ready` low for 5 cycles -> `dout` and `tx_valid` stay stable for 5 cycles; the second word appears only after the handshake.
- Dropped command: issue opcode 01 during HOLD -> `cmd_err` pulses exactly one cycle; RAM and wr_addr are unchanged (checked by a later read).
- Reset mid-burst: assert `rst` in HOLD -> `tx_valid` drops immediately; after release, state is IDLE and rd_addr=0; RAM data written earlier still reads back correctly.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - shared opcodes, FSM state encoding and command helpers for spi_burst_ram
package spi_ram_pkg;

  localparam logic [1:0] OP_SET_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_SET_RADDR = 2'b10;
  localparam logic [1:0] OP_READ      = 2'b11;

  // IDLE accepts commands; FETCH reads one word; HOLD presents it until taken
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Opcode sits in the two bits above the payload
  function automatic logic [1:0] cmd_opcode(input logic [1:0] hi_bits);
    return hi_bits;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - synchronous single-port RAM with registered, read-enabled output
module sp_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Output register only loads on a read so the word stays put while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_burst_ram.sv
// rtl/spi_burst_ram.sv - command-decoded RAM with auto-increment writes and back-pressured burst reads
module spi_burst_ram
  import spi_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int LEN_W    = 4,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              cmd_err
);

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              tx_take;

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  remaining;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign opcode  = cmd_opcode(din[DATA_W+1:DATA_W]);
  assign payload = din[DATA_W-1:0];
  assign accept  = rx_valid && rx_ready;
  assign tx_take = tx_valid && tx_ready;

  // The port only reads during FETCH, so every other cycle it serves the write address
  assign ram_addr = (state == FETCH) ? rd_addr : wr_addr;
  assign dout     = ram_rdata;

  sp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (payload),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, command acceptance and RAM strobes
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    case (state)
      IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (opcode == OP_WRITE) begin
            ram_we = 1'b1;
          end
          if (opcode == OP_READ) begin
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        ram_re    = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (tx_take) begin
          state_nxt = (remaining == '0) ? IDLE : FETCH;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write address: loaded by SET_WADDR, optionally advanced after each data write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr <= '0;
    end else if (accept && opcode == OP_SET_WADDR) begin
      wr_addr <= payload[ADDR_W-1:0];
    end else if (accept && opcode == OP_WRITE && AUTO_INC != 0) begin
      wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  // Read address: loaded by SET_RADDR, advanced once per fetched word so bursts chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (accept && opcode == OP_SET_RADDR) begin
      rd_addr <= payload[ADDR_W-1:0];
    end else if (state == FETCH) begin
      rd_addr <= rd_addr + ADDR_W'(1);
    end
  end

  // Words still owed after the current one; counts down on each handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (accept && opcode == OP_READ) begin
      remaining <= payload[LEN_W-1:0];
    end else if (state == HOLD && tx_take && remaining != '0) begin
      remaining <= remaining - LEN_W'(1);
    end
  end

  // Output valid: raised with the fetched word, dropped on the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid <= 1'b0;
    end else if (state == FETCH) begin
      tx_valid <= 1'b1;
    end else if (state == HOLD && tx_take) begin
      tx_valid <= 1'b0;
    end
  end

  // One pulse per command offered while the block was busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= rx_valid && !rx_ready;
    end
  end

endmodule
